// File: rtl/clint_pkg.sv
// Shared register map, CTRL field positions and reset constants for the CLINT timer.
package clint_pkg;

    localparam logic [4:0] CLINT_MTIME_LO    = 5'h00;
    localparam logic [4:0] CLINT_MTIME_HI    = 5'h04;
    localparam logic [4:0] CLINT_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] CLINT_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] CLINT_MSIP        = 5'h10;
    localparam logic [4:0] CLINT_CTRL        = 5'h14;

    localparam int unsigned CLINT_CTRL_EN_BIT       = 0;
    localparam int unsigned CLINT_CTRL_PRESCALE_LSB = 8;

    localparam logic [63:0] CLINT_MTIMECMP_RESET = '1;

endpackage

// File: rtl/clint_prescaler.sv
// Tick prescaler: emits one tick every PRESCALE+1 enabled cycles; clear restarts the count.
module clint_prescaler #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_prescale,
    output logic             o_tick
);

    logic [WIDTH-1:0] r_count;
    logic             w_wrap;

    assign w_wrap = (r_count == i_prescale);
    // A clear cycle never ticks, so a CTRL write always starts a full period.
    assign o_tick = i_enable && !i_clear && w_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (w_wrap) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Memory-mapped machine timer / software interrupt source (MTIME, MTIMECMP, MSIP, CTRL).
// Optional CLINT_TIMER_HI_LATCH_EN: MTIME_LO reads snapshot MTIME_HI for atomic LO/HI pairs.
module clint_timer
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    output logic        bus_ack,
    output logic        interruption_request_timer,
    output logic        interruption_request_software,
    output logic [63:0] time_value
);

    logic [63:0]               r_mtime;
    logic [63:0]               r_mtimecmp;
    logic                      r_msip;
    logic                      r_enable;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      r_ack;
    logic [31:0]               r_rdata;
    logic                      r_irq_timer;
`ifdef CLINT_TIMER_HI_LATCH_EN
    logic [31:0]               r_mtime_hi_shadow;
`endif

    logic        w_hit;
    logic [4:0]  w_offset;
    logic        w_wr;
    logic        w_rd;
    logic        w_tick;
    logic        w_ctrl_wr;
    logic        w_mtime_lo_wr;
    logic        w_mtime_hi_wr;
    logic [31:0] w_rdata_mux;
    logic [31:0] w_ctrl_value;
    logic        w_unused;

    assign w_unused      = ^bus_address[1:0];
    assign w_hit         = (bus_address[31:5] == BASE_ADDR[31:5]);
    assign w_offset      = {bus_address[4:2], 2'b00};
    assign w_wr          = w_hit && bus_write;
    // A combined read+write strobe is treated as a write that returns zero data.
    assign w_rd          = w_hit && bus_read && !bus_write;
    assign w_ctrl_wr     = w_wr && (w_offset == CLINT_CTRL);
    assign w_mtime_lo_wr = w_wr && (w_offset == CLINT_MTIME_LO);
    assign w_mtime_hi_wr = w_wr && (w_offset == CLINT_MTIME_HI);

    clint_prescaler #(
        .WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .i_enable  (r_enable),
        .i_clear   (w_ctrl_wr),
        .i_prescale(r_prescale),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_ctrl_value = '0;
        w_ctrl_value[CLINT_CTRL_EN_BIT] = r_enable;
        w_ctrl_value[CLINT_CTRL_PRESCALE_LSB +: PRESCALE_WIDTH] = r_prescale;
    end

    always_comb begin
        w_rdata_mux = '0;
        case (w_offset)
            CLINT_MTIME_LO:    w_rdata_mux = r_mtime[31:0];
`ifdef CLINT_TIMER_HI_LATCH_EN
            CLINT_MTIME_HI:    w_rdata_mux = r_mtime_hi_shadow;
`else
            CLINT_MTIME_HI:    w_rdata_mux = r_mtime[63:32];
`endif
            CLINT_MTIMECMP_LO: w_rdata_mux = r_mtimecmp[31:0];
            CLINT_MTIMECMP_HI: w_rdata_mux = r_mtimecmp[63:32];
            CLINT_MSIP:        w_rdata_mux = {31'd0, r_msip};
            CLINT_CTRL:        w_rdata_mux = w_ctrl_value;
            default:           w_rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtime     <= '0;
            r_mtimecmp  <= CLINT_MTIMECMP_RESET;
            r_msip      <= 1'b0;
            r_enable    <= 1'b1;
            r_prescale  <= '0;
            r_ack       <= 1'b0;
            r_rdata     <= '0;
            r_irq_timer <= 1'b0;
        end else begin
            r_ack       <= w_hit && (bus_read || bus_write);
            r_rdata     <= w_rd ? w_rdata_mux : '0;
            r_irq_timer <= (r_mtime >= r_mtimecmp);

            // Software writes to either MTIME half take priority over the tick.
            if (w_mtime_lo_wr || w_mtime_hi_wr) begin
                if (w_mtime_lo_wr) r_mtime[31:0]  <= bus_write_data;
                if (w_mtime_hi_wr) r_mtime[63:32] <= bus_write_data;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (w_wr) begin
                case (w_offset)
                    CLINT_MTIMECMP_LO: r_mtimecmp[31:0]  <= bus_write_data;
                    CLINT_MTIMECMP_HI: r_mtimecmp[63:32] <= bus_write_data;
                    CLINT_MSIP:        r_msip            <= bus_write_data[0];
                    CLINT_CTRL: begin
                        r_enable   <= bus_write_data[CLINT_CTRL_EN_BIT];
                        r_prescale <= bus_write_data[CLINT_CTRL_PRESCALE_LSB +: PRESCALE_WIDTH];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef CLINT_TIMER_HI_LATCH_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtime_hi_shadow <= '0;
        end else if (w_rd && (w_offset == CLINT_MTIME_LO)) begin
            r_mtime_hi_shadow <= r_mtime[63:32];
        end
    end
`endif

    assign bus_ack                       = r_ack;
    assign bus_read_data                 = r_rdata;
    assign interruption_request_timer    = r_irq_timer;
    assign interruption_request_software = r_msip;
    assign time_value                    = r_mtime;

endmodule
